// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage PCPU: load-use bubbles, dmem-wait freeze
// with timeout, redirect flushes, and saturating stall/flush counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow; load-use and redirect rules apply
//   MEM_WAIT | MEM access outstanding; pipeline frozen until dmem_ready
//   ERR      | dmem wait hit MAX_WAIT; frozen until rst, mem_timeout high
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_redirect,
  input  logic             MEM_req,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic               freeze;
  logic               load_use;
  logic               redirect_act;

  assign freeze = (state == RUN && MEM_req && !dmem_ready) ||
                  (state == MEM_WAIT && !dmem_ready) ||
                  (state == ERR);

  assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                    ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));

  // A redirect during freeze is dropped here; EX holds it and re-presents it later.
  assign redirect_act = !freeze && EX_redirect;

  assign mem_timeout = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (MEM_req && !dmem_ready) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_write  = 1'b1;
    MEM_WB_bubble = 1'b0;
    if (freeze) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (EX_redirect) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PC_write && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_act && !(&flush_count))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
